debouncer_bank: RTL and testbench
=================================

# debouncer_bank

Multi-channel, parametrised input debouncer for the board I/O path: N asynchronous inputs (buttons, switches, PMOD lines) are synchronised, filtered against a shared programmable debounce time, and turned into clean levels, one-cycle edge pulses and sticky interrupt flags. It sits between the pad inputs and the register/interrupt logic. It replaces single-channel instances with one shared timebase.

## Interface
Parameters:
- N_CH, 8, number of channels (1..32)
- PRESC_DIV, 10000, clk cycles per debounce tick (10000 = 100 us at 100 MHz); must be >= 2
- TIME_W, 5, width of deb_time

Ports:
- clk  in  1  system clock, 100 MHz nominal
- res_n  in  1  reset; asynchronous, active-low
- ena  in  1  1 = filtering active; 0 = bypass (synchronised input passed through)
- deb_time  in  TIME_W  debounce time in ticks, shared by all channels; sampled every cycle
- rise_en  in  N_CH  per-channel enable for rising-edge flag capture
- fall_en  in  N_CH  per-channel enable for falling-edge flag capture
- evt_clr  in  N_CH  write-1-to-clear pulse for evt
- data_in  in  N_CH  raw asynchronous inputs
- data_out  out  N_CH  filtered level, registered
- rise  out  N_CH  1-cycle pulse on data_out 0->1
- fall  out  N_CH  1-cycle pulse on data_out 1->0
- evt  out  N_CH  sticky edge flags
- irq  out  1  OR of evt, registered

## Operation
- Synchroniser: 2 flops per channel; sync = second flop.
- Prescaler: counter 0..PRESC_DIV-1, ceil(log2(PRESC_DIV)) bits. tick = 1 when count = PRESC_DIV-1, then wraps to 0. When ena=0, counter held at 0 and tick = 0.
- Per-channel counter cnt is TIME_W+1 bits. Each cycle with ena=1:
  - sync == fil: cnt <= 0.
  - sync != fil and tick and cnt == deb_time: fil <= sync, cnt <= 0.
  - sync != fil and tick otherwise: cnt <= cnt+1, saturating at all-ones.
  - no tick: hold.
- A mismatch must persist for deb_time+1 ticks to be accepted. Any return to equality restarts the count.
- deb_time lowered below the current cnt: that channel waits until saturation. The change is not retroactive. Software changes deb_time only while ena=0.
- ena=0: fil <= sync every cycle and cnt <= 0. Re-enabling therefore causes no spurious edge.
- data_out = fil.
- rise/fall: fil_d is fil delayed 1 cycle. rise = fil & ~fil_d; fall = ~fil & fil_d. Both are registered outputs, and they fire in bypass mode as well.
- evt[i] <= (rise[i]&rise_en[i]) | (fall[i]&fall_en[i]) | (evt[i] & ~evt_clr[i]). If set and clear occur in the same cycle, set wins.
- irq <= |evt_next. irq therefore asserts in the same cycle as evt.

## Timing
- Reset values: every flop is 0. data_out, rise, fall, evt and irq all read 0.
- Bypass latency: data_in -> data_out is 3 clk. rise/fall follow 1 cycle later.
- Filtered latency when ena is already high is between deb_time*PRESC_DIV+3 and (deb_time+1)*PRESC_DIV+3 cycles. The spread comes from tick phase jitter.
- When ena rises with a mismatch already present, the first tick comes PRESC_DIV cycles after ena rises.
- An input that is high at reset release in bypass mode produces a rise pulse about 4 cycles later. This is intended.
- A reset in mid-count clears all counters and flags. No pulses are generated on reset assertion.

## Structure
- Package debouncer_pkg holds:
  - default constants DEB_PRESC_DIV_100US = 10000 and DEB_TIME_W = 5;
  - a function that returns the prescaler width from PRESC_DIV.
- Sub-module debouncer_ch: one channel. It contains the synchroniser, cnt, fil, edge detection and evt. Inputs are tick and ena.
- The top instantiates the prescaler once, generates N_CH debouncer_ch instances, and implements the irq OR.

## Test plan
Bench parameters: N_CH=4, PRESC_DIV=4, deb_time=2.
- Reset and bypass: with ena=0, set data_in[0] 0->1 -> data_out[0]=1 exactly 3 cycles later, rise[0] one cycle after that. evt[0] stays 0 while rise_en=0.
- Stable press: with ena=1, hold data_in[1]=1 for 20 cycles -> data_out[1] rises between 8+3 and 12+3 cycles after the change. rise[1] pulses once. With rise_en[1]=1, evt[1]=1 and irq=1.
- Bounce: toggle data_in[2] every 5 cycles for 40 cycles -> data_out[2] stays 0; no rise or fall pulses.
- Sticky clear: with evt[1]=1, pulse evt_clr[1] -> evt[1]=0 and irq=0 next cycle. Repeat with a fall edge on channel 1 (fall_en=1) in the same cycle as the clear -> evt[1] stays 1.
- Enable toggle: while data_in[3]=1 in bypass (data_out[3]=1), set ena=1 -> no fall or rise pulse. Then drop data_in[3] -> fall after about 12-15 cycles.
- Asynchronous reset mid-count: deassert res_n partway through a count -> all outputs go 0 immediately. After release, counting restarts from 0.

Source files
------------

// File: rtl/debouncer_pkg.sv
// -----------------------------------------------------------------------------
// debouncer_pkg
// Shared constants and helpers for the multi-channel input debouncer.
//   DEB_PRESC_DIV_100US : clk cycles per debounce tick (100 us at 100 MHz)
//   DEB_TIME_W          : default width of the debounce-time field
//   presc_width()       : number of bits needed for a 0..div-1 prescaler
// -----------------------------------------------------------------------------
package debouncer_pkg;

    localparam int DEB_PRESC_DIV_100US = 10000;
    localparam int DEB_TIME_W          = 5;

    // ceil(log2(div)) for div >= 2; never returns less than 1 bit.
    function automatic int presc_width(input int div);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < div) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/debouncer_ch.sv
// -----------------------------------------------------------------------------
// debouncer_ch
// One debounce channel: 2-flop synchroniser, tick-driven mismatch counter,
// filtered level, registered edge pulses and a sticky edge flag.
// Ports:
//   clk, res_n  : clock, asynchronous active-low reset
//   ena         : 1 = filter, 0 = pass the synchronised input straight through
//   tick        : shared timebase strobe from the prescaler
//   deb_time    : ticks of persistent mismatch required (minus one)
//   rise_en/fall_en : enable flag capture on the respective edge
//   evt_clr     : write-1-to-clear for the sticky flag
//   data_in     : raw asynchronous pad input
//   data_out    : filtered level
//   rise/fall   : 1-cycle pulses on data_out transitions
//   evt         : sticky flag; evt_next is its next-state value for the irq OR
// -----------------------------------------------------------------------------
module debouncer_ch
    import debouncer_pkg::*;
#(
    parameter int TIME_W = DEB_TIME_W
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              ena,
    input  logic              tick,
    input  logic [TIME_W-1:0] deb_time,
    input  logic              rise_en,
    input  logic              fall_en,
    input  logic              evt_clr,
    input  logic              data_in,
    output logic              data_out,
    output logic              rise,
    output logic              fall,
    output logic              evt,
    output logic              evt_next
);

    // The counter is one bit wider than deb_time so it can saturate above any
    // programmable value; a channel whose deb_time was lowered below its
    // current count waits for saturation instead of accepting early.
    localparam logic [TIME_W:0] CNT_ZERO = {(TIME_W+1){1'b0}};
    localparam logic [TIME_W:0] CNT_ONE  = {{TIME_W{1'b0}}, 1'b1};
    localparam logic [TIME_W:0] CNT_MAX  = {(TIME_W+1){1'b1}};

    logic              sync1_r;
    logic              sync2_r;
    logic              fil_r;
    logic              fil_d_r;
    logic [TIME_W:0]   cnt_r;
    logic              rise_r;
    logic              fall_r;
    logic              evt_r;

    logic              fil_next_s;
    logic [TIME_W:0]   cnt_next_s;
    logic              evt_next_s;

    // Filter next-state: accept the synchronised level only after it has
    // differed from the filtered level for deb_time+1 consecutive ticks.
    always_comb begin
        fil_next_s = fil_r;
        cnt_next_s = cnt_r;
        if (!ena) begin
            fil_next_s = sync2_r;
            cnt_next_s = CNT_ZERO;
        end else if (sync2_r == fil_r) begin
            cnt_next_s = CNT_ZERO;
        end else if (tick) begin
            if (cnt_r == {1'b0, deb_time}) begin
                fil_next_s = sync2_r;
                cnt_next_s = CNT_ZERO;
            end else if (cnt_r != CNT_MAX) begin
                cnt_next_s = cnt_r + CNT_ONE;
            end else begin
                cnt_next_s = cnt_r;
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Sticky flag next-state: a set in the same cycle as a clear wins.
    always_comb begin
        evt_next_s = (rise_r & rise_en) | (fall_r & fall_en) | (evt_r & ~evt_clr);
    end

    // Channel state: synchroniser, filter, edge pulses and sticky flag.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            fil_r   <= 1'b0;
            fil_d_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            evt_r   <= 1'b0;
        end else begin
            sync1_r <= data_in;
            sync2_r <= sync1_r;
            fil_r   <= fil_next_s;
            cnt_r   <= cnt_next_s;
            fil_d_r <= fil_r;
            rise_r  <= fil_r & ~fil_d_r;
            fall_r  <= ~fil_r & fil_d_r;
            evt_r   <= evt_next_s;
        end
    end

    assign data_out = fil_r;
    assign rise     = rise_r;
    assign fall     = fall_r;
    assign evt      = evt_r;
    assign evt_next = evt_next_s;

endmodule

// File: rtl/debouncer_bank.sv
// -----------------------------------------------------------------------------
// debouncer_bank
// N_CH-channel input debouncer sharing one prescaled timebase.
// Ports:
//   clk, res_n  : clock, asynchronous active-low reset
//   ena         : 1 = filtering active, 0 = bypass
//   deb_time    : shared debounce time in ticks
//   rise_en, fall_en, evt_clr : per-channel flag capture enables / clear
//   data_in     : raw asynchronous inputs
//   data_out    : filtered levels
//   rise, fall  : per-channel 1-cycle edge pulses
//   evt         : per-channel sticky edge flags
//   irq         : registered OR of all flags (same cycle as evt)
// -----------------------------------------------------------------------------
module debouncer_bank
    import debouncer_pkg::*;
#(
    parameter int N_CH      = 8,
    parameter int PRESC_DIV = DEB_PRESC_DIV_100US,
    parameter int TIME_W    = DEB_TIME_W
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              ena,
    input  logic [TIME_W-1:0] deb_time,
    input  logic [N_CH-1:0]   rise_en,
    input  logic [N_CH-1:0]   fall_en,
    input  logic [N_CH-1:0]   evt_clr,
    input  logic [N_CH-1:0]   data_in,
    output logic [N_CH-1:0]   data_out,
    output logic [N_CH-1:0]   rise,
    output logic [N_CH-1:0]   fall,
    output logic [N_CH-1:0]   evt,
    output logic              irq
);

    localparam int            PW         = presc_width(PRESC_DIV);
    localparam logic [PW-1:0] PCNT_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PCNT_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PCNT_LAST  = PW'(PRESC_DIV - 1);

    logic [PW-1:0]   pcnt_r;
    logic            tick_s;
    logic [N_CH-1:0] evt_next_s;
    logic            irq_r;

    // Tick strobe on the last prescaler count; suppressed in bypass.
    always_comb begin
        if (ena && (pcnt_r == PCNT_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Prescaler: held at zero while bypassed so the first tick after enable
    // always comes a full period later.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pcnt_r <= PCNT_ZERO;
        end else if (!ena) begin
            pcnt_r <= PCNT_ZERO;
        end else if (tick_s) begin
            pcnt_r <= PCNT_ZERO;
        end else begin
            pcnt_r <= pcnt_r + PCNT_ONE;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            debouncer_ch #(
                .TIME_W (TIME_W)
            ) u_ch (
                .clk      (clk),
                .res_n    (res_n),
                .ena      (ena),
                .tick     (tick_s),
                .deb_time (deb_time),
                .rise_en  (rise_en[gi]),
                .fall_en  (fall_en[gi]),
                .evt_clr  (evt_clr[gi]),
                .data_in  (data_in[gi]),
                .data_out (data_out[gi]),
                .rise     (rise[gi]),
                .fall     (fall[gi]),
                .evt      (evt[gi]),
                .evt_next (evt_next_s[gi])
            );
        end
    endgenerate

    // Interrupt from the flags' next state so it lines up with evt.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |evt_next_s;
        end
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_debouncer_bank.sv
// -----------------------------------------------------------------------------
// tb_debouncer_bank
// Directed steps followed by a randomized phase, every cycle compared against
// a behavioural model: input history queue, tick phase from the number of
// cycles ena has been high, and a per-channel count of ticks seen during the
// current mismatch.
// -----------------------------------------------------------------------------
module tb_debouncer_bank;

    localparam int N   = 4;
    localparam int P   = 4;
    localparam int TW  = 5;
    localparam int DEB = 2;

    logic          clk = 1'b0;
    logic          res_n = 1'b0;
    logic          ena = 1'b0;
    logic [TW-1:0] deb_time = 5'd2;
    logic [N-1:0]  rise_en = 4'b0000;
    logic [N-1:0]  fall_en = 4'b0000;
    logic [N-1:0]  evt_clr = 4'b0000;
    logic [N-1:0]  data_in = 4'b0000;
    logic [N-1:0]  data_out;
    logic [N-1:0]  rise;
    logic [N-1:0]  fall;
    logic [N-1:0]  evt;
    logic          irq;

    int tests = 0;
    int fails = 0;

    // model state
    logic [N-1:0] m_hist[$];      // sampled inputs, oldest first
    logic [N-1:0] m_fil, m_prev_fil, m_rise, m_fall, m_evt;
    logic         m_irq;
    int           m_ena_cycles;
    int           m_ticks[N];

    debouncer_bank #(.N_CH(N), .PRESC_DIV(P), .TIME_W(TW)) dut (
        .clk(clk), .res_n(res_n), .ena(ena), .deb_time(deb_time),
        .rise_en(rise_en), .fall_en(fall_en), .evt_clr(evt_clr),
        .data_in(data_in), .data_out(data_out), .rise(rise), .fall(fall),
        .evt(evt), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = {4'b0000, 4'b0000};
        m_fil = '0; m_prev_fil = '0; m_rise = '0; m_fall = '0; m_evt = '0;
        m_irq = 1'b0;
        m_ena_cycles = 0;
        for (int c = 0; c < N; c++) m_ticks[c] = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] sync, nf, nr, nfa, ne;
        bit tick;
        if (!res_n) begin
            model_reset();
            return;
        end
        sync = m_hist[0];
        tick = ena && ((m_ena_cycles % P) == (P - 1));
        nf = m_fil;
        for (int c = 0; c < N; c++) begin
            if (!ena) begin
                nf[c] = sync[c];
                m_ticks[c] = 0;
            end else if (sync[c] == m_fil[c]) begin
                m_ticks[c] = 0;
            end else if (tick) begin
                m_ticks[c]++;
                if (m_ticks[c] == DEB + 1) begin
                    nf[c] = sync[c];
                    m_ticks[c] = 0;
                end
            end
        end
        nr  = m_fil & ~m_prev_fil;
        nfa = ~m_fil & m_prev_fil;
        ne  = (m_rise & rise_en) | (m_fall & fall_en) | (m_evt & ~evt_clr);
        m_irq = |ne;
        m_prev_fil = m_fil;
        m_fil = nf; m_rise = nr; m_fall = nfa; m_evt = ne;
        void'(m_hist.pop_front());
        m_hist.push_back(data_in);
        m_ena_cycles = ena ? m_ena_cycles + 1 : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("data_out", 32'(data_out), 32'(m_fil));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("evt", 32'(evt), 32'(m_evt));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    initial begin
        int lat;
        int cnt;
        bit found;
        model_reset();
        // reset held for a few cycles
        repeat (3) step();
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_evt", 32'(evt), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        res_n = 1'b1;
        repeat (2) step();

        // bypass latency on channel 0
        data_in[0] = 1'b1;
        step(); step();
        chk("byp_lat2", 32'(data_out[0]), 32'd0);
        step();
        chk("byp_lat3", 32'(data_out[0]), 32'd1);
        chk("byp_no_early_rise", 32'(rise[0]), 32'd0);
        step();
        chk("byp_rise", 32'(rise[0]), 32'd1);
        step();
        chk("byp_evt_off", 32'(evt[0]), 32'd0);

        // stable press on channel 1
        ena = 1'b1;
        rise_en = 4'b0010;
        repeat (5) step();
        data_in[1] = 1'b1;
        lat = 99; cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (data_out[1] && lat == 99) lat = k;
            if (rise[1]) cnt++;
        end
        chk("press_lat_range", 32'((lat >= 11) && (lat <= 15)), 32'd1);
        chk("press_rise_once", 32'(cnt), 32'd1);
        chk("press_evt", 32'(evt[1]), 32'd1);
        chk("press_irq", 32'(irq), 32'd1);

        // bounce on channel 2
        lat = 0; cnt = 0;
        for (int b = 0; b < 8; b++) begin
            data_in[2] = ~data_in[2];
            repeat (5) begin
                step();
                if (data_out[2]) lat++;
                if (rise[2] || fall[2]) cnt++;
            end
        end
        chk("bounce_level", 32'(lat), 32'd0);
        chk("bounce_edges", 32'(cnt), 32'd0);

        // sticky clear, then set-wins-over-clear
        chk("sticky_pre", 32'(evt[1]), 32'd1);
        evt_clr = 4'b0010;
        step();
        evt_clr = 4'b0000;
        chk("clr_evt", 32'(evt[1]), 32'd0);
        chk("clr_irq", 32'(irq), 32'd0);
        fall_en = 4'b0010;
        data_in[1] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (fall[1]) found = 1'b1;
        end
        chk("fall_seen", 32'(found), 32'd1);
        evt_clr = 4'b0010;
        step();
        evt_clr = 4'b0000;
        chk("set_wins_evt", 32'(evt[1]), 32'd1);
        chk("set_wins_irq", 32'(irq), 32'd1);
        evt_clr = 4'b0010;
        step();
        evt_clr = 4'b0000;
        chk("clr2_evt", 32'(evt[1]), 32'd0);

        // enable toggle with channel 3 already high
        ena = 1'b0;
        data_in[3] = 1'b1;
        repeat (5) step();
        chk("byp_ch3_high", 32'(data_out[3]), 32'd1);
        ena = 1'b1;
        cnt = 0;
        repeat (6) begin
            step();
            if (rise[3] || fall[3]) cnt++;
        end
        chk("ena_no_edge", 32'(cnt), 32'd0);
        chk("ena_ch3_level", 32'(data_out[3]), 32'd1);
        data_in[3] = 1'b0;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (fall[3] && lat == 99) lat = k;
        end
        chk("ch3_fall_lat", 32'((lat >= 12) && (lat <= 15)), 32'd1);

        // asynchronous reset in the middle of a count on channel 0
        data_in[0] = 1'b0;
        repeat (6) step();
        chk("pre_rst_out0", 32'(data_out[0]), 32'd1);
        #2;
        res_n = 1'b0;
        model_reset();
        #1;
        chk("arst_data_out", 32'(data_out), 32'd0);
        chk("arst_rise_fall", 32'({rise, fall}), 32'd0);
        chk("arst_evt", 32'(evt), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        repeat (2) step();
        res_n = 1'b1;
        data_in[0] = 1'b1;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (data_out[0] && lat == 99) lat = k;
        end
        chk("restart_lat", 32'(lat), 32'd12);

        // randomized phase against the model
        rise_en = 4'b1111;
        fall_en = 4'b1111;
        for (int i = 0; i < 900; i++) begin
            res_n = 1'b1;
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 11) == 0) data_in[c] = ~data_in[c];
                evt_clr[c] = ($urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 79) == 0) ena = ~ena;
            if ($urandom_range(0, 49) == 0) begin
                rise_en = 4'($urandom);
                fall_en = 4'($urandom);
            end
            if ($urandom_range(0, 299) == 0) begin
                #2;
                res_n = 1'b0;
                model_reset();
                #1;
                chk("rnd_arst_out", 32'({data_out, evt, irq}), 32'd0);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
